// File: rtl/viola_pkg.sv
// Shared opcode encoding, tag width and load/store range for the viola core.
package viola_pkg;

    localparam int TAG_W = 3;

    localparam logic [4:0] ADD   = 5'd0;
    localparam logic [4:0] SUB   = 5'd1;
    localparam logic [4:0] AND_C = 5'd2;
    localparam logic [4:0] OR_C  = 5'd3;
    localparam logic [4:0] XOR_C = 5'd4;
    localparam logic [4:0] SLL   = 5'd5;
    localparam logic [4:0] SRL   = 5'd6;
    localparam logic [4:0] SRA   = 5'd7;
    localparam logic [4:0] SLT   = 5'd8;
    localparam logic [4:0] SLTU  = 5'd9;
    localparam logic [4:0] BEQ   = 5'd10;
    localparam logic [4:0] BNE   = 5'd11;
    localparam logic [4:0] BLT   = 5'd12;
    localparam logic [4:0] BGE   = 5'd13;
    localparam logic [4:0] BLTU  = 5'd14;
    localparam logic [4:0] BGEU  = 5'd15;
    localparam logic [4:0] LUI   = 5'd16;
    localparam logic [4:0] AUIPC = 5'd17;
    localparam logic [4:0] LB    = 5'd18;
    localparam logic [4:0] LH    = 5'd19;
    localparam logic [4:0] LW    = 5'd20;
    localparam logic [4:0] LBU   = 5'd21;
    localparam logic [4:0] LHU   = 5'd22;
    localparam logic [4:0] SB    = 5'd23;
    localparam logic [4:0] SH    = 5'd24;
    localparam logic [4:0] SW    = 5'd25;
    localparam logic [4:0] JAL_C = 5'd26;

    localparam logic [4:0] OP_NONE = 5'b11111;
    localparam logic [4:0] LS_LO   = 5'b10010;
    localparam logic [4:0] LS_HI   = 5'b11001;

    function automatic logic is_ls(input logic [4:0] op);
        return (op >= LS_LO) && (op <= LS_HI);
    endfunction

endpackage

// File: rtl/rs_picker.sv
// Lowest-index priority encoder: reports whether any request bit is set and the first one.
module rs_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);
    localparam int IDX_W = $clog2(N);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: buffers dispatched ops, snoops ALU/memory result broadcasts,
// and issues the lowest-index ready entry each cycle.
module reservation_station #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [4:0]       op_in,
    input  logic [31:0]      value1_in,
    input  logic [31:0]      value2_in,
    input  logic [TAG_W-1:0] query1_in,
    input  logic [TAG_W-1:0] query2_in,
    input  logic [TAG_W-1:0] target_in,
    input  logic [31:0]      imm_in,
    input  logic             is_branch_in,
    input  logic [TAG_W-1:0] alu_num,
    input  logic [31:0]      alu_value,
    input  logic [TAG_W-1:0] mem_num,
    input  logic [31:0]      mem_value,
    output logic             rs_full,
    output logic [4:0]       alu_op,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [31:0]      alu_imm,
    output logic [TAG_W-1:0] alu_target,
    output logic             alu_is_branch,
    output logic             rs_overflow
);
    import viola_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] busy;
    logic [4:0]       op  [DEPTH];
    logic [31:0]      v1  [DEPTH];
    logic [31:0]      v2  [DEPTH];
    logic [TAG_W-1:0] q1  [DEPTH];
    logic [TAG_W-1:0] q2  [DEPTH];
    logic [31:0]      imm [DEPTH];
    logic [TAG_W-1:0] tgt [DEPTH];
    logic             br  [DEPTH];

    logic [DEPTH-1:0] free_vec;
    logic [DEPTH-1:0] ready_vec;
    logic             free_found;
    logic             ready_found;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] ready_idx;
    logic             dispatch;
    logic             do_insert;
    logic             overflow_evt;
    logic             full_next;
    int               occ;

    function automatic logic tag_hit(input logic [TAG_W-1:0] q, input logic [TAG_W-1:0] num);
        return (q != '0) && (q == num);
    endfunction

    // Both vectors come from registered state, so a slot freed by issue is only visible next cycle.
    always_comb begin
        free_vec  = ~busy;
        ready_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = busy[i] && (q1[i] == '0) && (q2[i] == '0);
        end
    end

    rs_picker #(.N(DEPTH)) u_free_pick (
        .req   (free_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_picker #(.N(DEPTH)) u_ready_pick (
        .req   (ready_vec),
        .found (ready_found),
        .idx   (ready_idx)
    );

    always_comb begin
        dispatch     = (op_in != OP_NONE) && !is_ls(op_in);
        do_insert    = dispatch && free_found;
        overflow_evt = dispatch && !free_found;
        occ          = 0;
        for (int i = 0; i < DEPTH; i++) begin
            occ = occ + int'(busy[i]);
        end
        occ       = occ + int'(do_insert) - int'(ready_found);
        full_next = (occ >= DEPTH - 1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy          <= '0;
            alu_op        <= OP_NONE;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_imm       <= '0;
            alu_target    <= '0;
            alu_is_branch <= 1'b0;
            rs_full       <= 1'b0;
            rs_overflow   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                op[i]  <= OP_NONE;
                v1[i]  <= '0;
                v2[i]  <= '0;
                q1[i]  <= '0;
                q2[i]  <= '0;
                imm[i] <= '0;
                tgt[i] <= '0;
                br[i]  <= 1'b0;
            end
        end else if (flush) begin
            busy    <= '0;
            alu_op  <= OP_NONE;
            rs_full <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i]) begin
                    if (tag_hit(q1[i], alu_num)) begin
                        v1[i] <= alu_value;
                        q1[i] <= '0;
                    end else if (tag_hit(q1[i], mem_num)) begin
                        v1[i] <= mem_value;
                        q1[i] <= '0;
                    end
                    if (tag_hit(q2[i], alu_num)) begin
                        v2[i] <= alu_value;
                        q2[i] <= '0;
                    end else if (tag_hit(q2[i], mem_num)) begin
                        v2[i] <= mem_value;
                        q2[i] <= '0;
                    end
                end
            end

            if (ready_found) begin
                busy[ready_idx] <= 1'b0;
                alu_op          <= op[ready_idx];
                alu_a           <= v1[ready_idx];
                alu_b           <= v2[ready_idx];
                alu_imm         <= imm[ready_idx];
                alu_target      <= tgt[ready_idx];
                alu_is_branch   <= br[ready_idx];
            end else begin
                alu_op <= OP_NONE;
            end

            // Insert slot is never the issued slot, and is not busy, so wakeup above never touches it.
            if (do_insert) begin
                busy[free_idx] <= 1'b1;
                op[free_idx]   <= op_in;
                imm[free_idx]  <= imm_in;
                tgt[free_idx]  <= target_in;
                br[free_idx]   <= is_branch_in;
                if (tag_hit(query1_in, alu_num)) begin
                    v1[free_idx] <= alu_value;
                    q1[free_idx] <= '0;
                end else if (tag_hit(query1_in, mem_num)) begin
                    v1[free_idx] <= mem_value;
                    q1[free_idx] <= '0;
                end else begin
                    v1[free_idx] <= value1_in;
                    q1[free_idx] <= query1_in;
                end
                if (tag_hit(query2_in, alu_num)) begin
                    v2[free_idx] <= alu_value;
                    q2[free_idx] <= '0;
                end else if (tag_hit(query2_in, mem_num)) begin
                    v2[free_idx] <= mem_value;
                    q2[free_idx] <= '0;
                end else begin
                    v2[free_idx] <= value2_in;
                    q2[free_idx] <= query2_in;
                end
            end

            if (overflow_evt) begin
                rs_overflow <= 1'b1;
            end
            rs_full <= full_next;
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: issue latency, wakeup, bypass, fill/overflow, flush, reset.
module tb_reservation_station;
    import viola_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [4:0]  op_in;
    logic [31:0] value1_in, value2_in, imm_in;
    logic [2:0]  query1_in, query2_in, target_in;
    logic        is_branch_in;
    logic [2:0]  alu_num, mem_num;
    logic [31:0] alu_value, mem_value;
    logic        rs_full;
    logic [4:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_imm;
    logic [2:0]  alu_target;
    logic        alu_is_branch;
    logic        rs_overflow;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    reservation_station #(.DEPTH(4), .TAG_W(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .op_in         (op_in),
        .value1_in     (value1_in),
        .value2_in     (value2_in),
        .query1_in     (query1_in),
        .query2_in     (query2_in),
        .target_in     (target_in),
        .imm_in        (imm_in),
        .is_branch_in  (is_branch_in),
        .alu_num       (alu_num),
        .alu_value     (alu_value),
        .mem_num       (mem_num),
        .mem_value     (mem_value),
        .rs_full       (rs_full),
        .alu_op        (alu_op),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_imm       (alu_imm),
        .alu_target    (alu_target),
        .alu_is_branch (alu_is_branch),
        .rs_overflow   (rs_overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        op_in        = OP_NONE;
        value1_in    = '0;
        value2_in    = '0;
        query1_in    = '0;
        query2_in    = '0;
        target_in    = '0;
        imm_in       = '0;
        is_branch_in = 1'b0;
        alu_num      = '0;
        alu_value    = '0;
        mem_num      = '0;
        mem_value    = '0;
    endtask

    task automatic dispatch(input logic [4:0] op, input logic [31:0] v1, input logic [31:0] v2,
                            input logic [2:0] q1, input logic [2:0] q2, input logic [2:0] tgt,
                            input logic [31:0] imm, input logic br);
        op_in        = op;
        value1_in    = v1;
        value2_in    = v2;
        query1_in    = q1;
        query2_in    = q2;
        target_in    = tgt;
        imm_in       = imm;
        is_branch_in = br;
    endtask

    initial begin
        rst   = 1'b0;
        flush = 1'b0;
        idle_inputs();
        tick();
        tick();
        check("reset_op", 32'(alu_op), 32'(OP_NONE));
        check("reset_full", 32'(rs_full), 32'd0);
        check("reset_ovf", 32'(rs_overflow), 32'd0);
        check("reset_a", alu_a, 32'd0);
        check("reset_target", 32'(alu_target), 32'd0);
        rst = 1'b1;

        // back-to-back issue
        dispatch(ADD, 32'd5, 32'd7, 3'd0, 3'd0, 3'd3, 32'd11, 1'b0);
        tick();
        idle_inputs();
        check("b2b_not_yet", 32'(alu_op), 32'(OP_NONE));
        tick();
        check("b2b_op", 32'(alu_op), 32'(ADD));
        check("b2b_a", alu_a, 32'd5);
        check("b2b_b", alu_b, 32'd7);
        check("b2b_target", 32'(alu_target), 32'd3);
        check("b2b_imm", alu_imm, 32'd11);
        tick();
        check("b2b_idle", 32'(alu_op), 32'(OP_NONE));
        check("b2b_hold_a", alu_a, 32'd5);

        // delayed wakeup on q1 via ALU broadcast
        dispatch(SUB, 32'd0, 32'd3, 3'd2, 3'd0, 3'd4, 32'd0, 1'b1);
        tick();
        idle_inputs();
        tick();
        check("wake_wait1", 32'(alu_op), 32'(OP_NONE));
        alu_num   = 3'd2;
        alu_value = 32'd40;
        tick();
        idle_inputs();
        check("wake_wait2", 32'(alu_op), 32'(OP_NONE));
        tick();
        check("wake_op", 32'(alu_op), 32'(SUB));
        check("wake_a", alu_a, 32'd40);
        check("wake_b", alu_b, 32'd3);
        check("wake_br", 32'(alu_is_branch), 32'd1);
        tick();
        check("wake_idle", 32'(alu_op), 32'(OP_NONE));

        // same-edge bypass from the memory broadcast
        dispatch(OR_C, 32'd1, 32'd0, 3'd0, 3'd4, 3'd5, 32'd0, 1'b0);
        mem_num   = 3'd4;
        mem_value = 32'd9;
        tick();
        idle_inputs();
        tick();
        check("byp_op", 32'(alu_op), 32'(OR_C));
        check("byp_a", alu_a, 32'd1);
        check("byp_b", alu_b, 32'd9);
        tick();

        // fill to four entries waiting on tag 5, then overflow
        for (int i = 1; i <= 4; i++) begin
            dispatch(XOR_C, 32'd0, 32'(i * 10), 3'd5, 3'd0, 3'(i), 32'd0, 1'b0);
            tick();
            if (i == 2) check("fill_full2", 32'(rs_full), 32'd0);
            if (i == 3) check("fill_full3", 32'(rs_full), 32'd1);
        end
        check("fill_no_ovf", 32'(rs_overflow), 32'd0);
        dispatch(XOR_C, 32'd0, 32'd99, 3'd0, 3'd0, 3'd6, 32'd0, 1'b0);
        tick();
        check("fill_ovf", 32'(rs_overflow), 32'd1);
        check("fill_no_issue", 32'(alu_op), 32'(OP_NONE));
        idle_inputs();
        alu_num   = 3'd5;
        alu_value = 32'd100;
        tick();
        idle_inputs();
        check("drain_pre", 32'(alu_op), 32'(OP_NONE));
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("drain_op", 32'(alu_op), 32'(XOR_C));
            check("drain_target", 32'(alu_target), 32'(i));
            check("drain_a", alu_a, 32'd100);
            check("drain_b", alu_b, 32'(i * 10));
            if (i == 1) check("drain_full1", 32'(rs_full), 32'd1);
            if (i == 2) check("drain_full2", 32'(rs_full), 32'd0);
        end
        tick();
        check("drain_idle", 32'(alu_op), 32'(OP_NONE));

        // flush with two waiting entries and a same-edge insert
        dispatch(ADD, 32'd0, 32'd1, 3'd6, 3'd0, 3'd1, 32'd0, 1'b0);
        tick();
        dispatch(SUB, 32'd0, 32'd2, 3'd6, 3'd0, 3'd2, 32'd0, 1'b0);
        tick();
        dispatch(AND_C, 32'd3, 32'd4, 3'd0, 3'd0, 3'd3, 32'd0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle_inputs();
        check("flush_op", 32'(alu_op), 32'(OP_NONE));
        check("flush_full", 32'(rs_full), 32'd0);
        check("flush_ovf_kept", 32'(rs_overflow), 32'd1);
        tick();
        check("flush_no_insert", 32'(alu_op), 32'(OP_NONE));
        alu_num   = 3'd6;
        alu_value = 32'd55;
        tick();
        idle_inputs();
        tick();
        check("flush_no_wake1", 32'(alu_op), 32'(OP_NONE));
        tick();
        check("flush_no_wake2", 32'(alu_op), 32'(OP_NONE));

        // load/store filter
        dispatch(LW, 32'd8, 32'd8, 3'd0, 3'd0, 3'd2, 32'd0, 1'b0);
        tick();
        idle_inputs();
        tick();
        check("ls_no_issue1", 32'(alu_op), 32'(OP_NONE));
        tick();
        check("ls_no_issue2", 32'(alu_op), 32'(OP_NONE));

        // reset while an instruction issues and another waits on tag 7
        dispatch(SLT, 32'd0, 32'd0, 3'd7, 3'd0, 3'd4, 32'd0, 1'b0);
        tick();
        dispatch(ADD, 32'd21, 32'd22, 3'd0, 3'd0, 3'd5, 32'd33, 1'b1);
        tick();
        idle_inputs();
        tick();
        check("mid_op", 32'(alu_op), 32'(ADD));
        check("mid_a", alu_a, 32'd21);
        rst = 1'b0;
        tick();
        check("rst_op", 32'(alu_op), 32'(OP_NONE));
        check("rst_a", alu_a, 32'd0);
        check("rst_b", alu_b, 32'd0);
        check("rst_imm", alu_imm, 32'd0);
        check("rst_target", 32'(alu_target), 32'd0);
        check("rst_br", 32'(alu_is_branch), 32'd0);
        check("rst_ovf", 32'(rs_overflow), 32'd0);
        check("rst_full", 32'(rs_full), 32'd0);
        rst       = 1'b1;
        alu_num   = 3'd7;
        alu_value = 32'd1;
        tick();
        idle_inputs();
        tick();
        check("rst_cleared_entry", 32'(alu_op), 32'(OP_NONE));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
# reservation_station

Holds instructions dispatched by the ROB until their source operands are available, captures results broadcast by the ALU and memory units, and issues one ready instruction per cycle to the ALU. It sits directly downstream of the reorder buffer: it consumes the ROB's `op_out`/`value*_out`/`query*_out`/`target`/`is_branch_out` stream and drives `rs_full` back to it. Load/store opcodes are not accepted; they go to the load/store buffer.

## Interface
- `DEPTH`, default 4: number of entries, minimum 2.
- `TAG_W`, default 3: ROB tag width. Tag 0 means "no tag / value present".
- `clk` input, 1 bit: single clock, all state updates on posedge.
- `rst` input, 1 bit: synchronous reset, active-low.
- `flush` input, 1 bit: synchronous clear of all entries, for mispredict recovery.
- `op_in` input, 5 bits: dispatched opcode. `5'b11111` means no dispatch.
- `value1_in`, `value2_in` input, 32 bits each: operand values, valid when the matching query is 0.
- `query1_in`, `query2_in` input, TAG_W bits each: producer tag, or 0 if the value is present.
- `target_in` input, TAG_W bits: ROB slot of this instruction.
- `imm_in` input, 32 bits: immediate, passed through.
- `is_branch_in` input, 1 bit: conditional-branch flag, passed through.
- `alu_num`, `mem_num` input, TAG_W bits each: result broadcast tags. 0 means idle.
- `alu_value`, `mem_value` input, 32 bits each: broadcast data.
- `rs_full` output, 1 bit: registered backpressure to the ROB.
- `alu_op` output, 5 bits: issued opcode, `5'b11111` means idle.
- `alu_a`, `alu_b`, `alu_imm` output, 32 bits each: operands and immediate for the issued instruction.
- `alu_target` output, TAG_W bits: ROB slot of the issued instruction.
- `alu_is_branch` output, 1 bit: branch flag of the issued instruction.
- `rs_overflow` output, 1 bit: sticky error, set when a dispatch arrives with no free entry.

## Operation
- Each entry holds busy, op, v1, v2, q1, q2, imm, target and is_branch.
- **Wakeup**, every cycle, for every busy entry: if `qk != 0` and `qk == alu_num`, then `vk <= alu_value` and `qk <= 0`. The same applies for `mem_num`/`mem_value`. If both broadcasts carry the same tag, the ALU broadcast wins.
- **Insert**: when `op_in != 5'b11111`, `op_in` is not in the load/store range `5'b10010..5'b11001`, and an entry is free:
  - write the lowest-index free entry;
  - apply same-edge bypass: a query matching this cycle's `alu_num`/`mem_num` is stored already resolved with the broadcast value.
- **Load/store filter**: load/store opcodes are ignored silently.
- **Overflow**: a dispatch with no free entry is dropped and sets `rs_overflow`, which clears only on reset.
- **Ready and select**: an entry is ready when busy, `q1 == 0` and `q2 == 0`, evaluated on the registered state before this edge's wakeup. The lowest-index ready entry is issued: the output registers load its fields and the entry's busy bit clears. If no entry is ready, `alu_op <= 5'b11111`; the other outputs hold.
- **Free-slot reuse**: an entry freed by issue at edge N may receive an insert at edge N+1, not at edge N.
- **`rs_full`**: registered, equal to (occupancy after this edge's insert and issue) >= `DEPTH-1`. The one-slot margin covers the ROB's one-cycle reaction to `rs_full`.
- **Flush**: clears all busy bits, sets `alu_op <= 5'b11111` and `rs_full <= 0`, and discards any same-edge insert. Flush has priority over insert and issue. `rs_overflow` is unaffected.
- **Reset** (`rst == 0`): all busy bits cleared, `alu_op = 5'b11111`, `rs_full = 0`, `rs_overflow = 0`, all other outputs 0. Reset takes effect mid-operation on the next edge, and overrides flush.

## Timing
- Insert at edge N with both operands present gives `alu_op` valid after edge N+1, so the minimum latency is 1 cycle.
- Insert at edge N waiting on tag T, with T broadcast at edge M >= N, gives issue after edge `max(N, M)+1`.
- At most one insert and one issue per edge.
- `alu_op` is valid for exactly one cycle per issued instruction.
- Tags wrap 7 -> 1 in the ROB. The station compares tags for equality only and has no ordering assumption.

## Structure
- Shared package `viola_pkg` holds:
  - opcode localparams (ADD..JAL_C);
  - `OP_NONE = 5'b11111`;
  - `TAG_W`;
  - the load/store range bounds.
- Sub-module `rs_picker`: combinational lowest-index priority encoder over a DEPTH-bit vector, returning a found flag and an index. It is instantiated twice: once for free-slot selection and once for ready selection.

## Test plan
- **Back-to-back issue:** reset, then dispatch ADD with `q1 = q2 = 0`, `v1 = 5`, `v2 = 7`, `target = 3` -> the next cycle shows `alu_op = ADD`, `alu_a = 5`, `alu_b = 7`, `alu_target = 3`, then `alu_op = 5'b11111`.
- **Delayed wakeup:** dispatch SUB with `q1 = 2`; two cycles later `alu_num = 2`, `alu_value = 40` -> SUB issues the cycle after, with `alu_a = 40`.
- **Same-edge bypass:** dispatch with `q2 = 4` on the same edge as `mem_num = 4`, `mem_value = 9` -> issue the next cycle with `alu_b = 9`.
- **Fill and overflow:** fill 4 entries all waiting on tag 5 -> `rs_full = 1` after the 3rd insert; a 5th dispatch sets `rs_overflow = 1`. Broadcasting tag 5 then issues entries 0, 1, 2, 3 on consecutive cycles.
- **Flush:** flush while 2 entries are busy and an insert is pending -> `alu_op = 5'b11111` from the next cycle, a later broadcast of the waited tag issues nothing, and `rs_full = 0`.
- **Load/store and reset mid-issue:** dispatch LW -> no entry is allocated and there is no issue. Assert `rst = 0` during an issue cycle -> all outputs at reset values on the next edge.
